ace_snapshot_loader: RTL and testbench
======================================

// Module: ace_snapshot_loader
// PURPOSE
//  Sequences host file downloads (ioctl byte stream) into Jupiter Ace main memory.
//  - Snapshot index: expands .ACE run-length compression.
//  - Other indices: copied raw.
//  Holds the machine in reset for the whole load and for a fixed hold time afterwards.
//  Throttles the host with ioctl_wait while a run is being expanded.
//  Position: between data_io and the ace core's loader_* write port.
// PARAMETERS
//  BASE_ADDR    16'h2000  first destination address of every download
//  MARKER       8'hED     RLE escape byte
//  SNAP_INDEX   8'h01     ioctl_index that selects RLE decoding
//  HOLD_CYCLES  64        clk_sys cycles loader_reset stays high after download ends (>=1)
// PORTS
//  clk_sys         in   1   system clock; all logic rising-edge
//  reset           in   1   synchronous, active-high
//  ioctl_download  in   1   high for the duration of a host transfer
//  ioctl_index     in   8   file type; sampled on ioctl_download rising edge
//  ioctl_wr        in   1   one-cycle strobe, ioctl_dout valid
//  ioctl_dout      in   8   download byte
//  ioctl_wait      out  1   host must not strobe while high
//  loader_en       out  1   memory port owned by loader
//  loader_addr     out  16  write address
//  loader_data     out  8   write data
//  loader_wr       out  1   one-cycle write strobe
//  loader_reset    out  1   machine reset request
//  load_done       out  1   one-cycle pulse when hold time expires
//  load_err        out  1   sticky error; cleared on next download start
// BEHAVIOUR
//  Reset values
//  - All outputs 0.
//  - FSM=IDLE, addr=BASE_ADDR.
//  FSM states
//  - IDLE -> LIT on download rise.
//    - Latches rle = (ioctl_index==SNAP_INDEX).
//    - Sets addr=BASE_ADDR, clears load_err.
//  - LIT: byte received.
//    - If rle and byte==MARKER -> MARK.
//    - Otherwise write byte at addr; addr++.
//  - MARK: count byte n.
//    - n==0 -> END (end-of-data marker).
//    - Else latch n -> VAL.
//  - VAL: value byte b.
//    - ioctl_wait rises next cycle.
//    - Write b n times on n consecutive cycles, addr++ each.
//    - ioctl_wait falls the cycle after the last write -> LIT.
//  - END: further bytes are ignored (no write, no error).
//  - Any state except IDLE/HOLD: download fall -> HOLD.
//    - A pending run is still completed first.
//    - A fall in MARK or VAL sets load_err.
//  - HOLD: counts HOLD_CYCLES, then load_done pulse -> IDLE.
//  Timing and outputs
//  - Literal latency: loader_wr 1 cycle after ioctl_wr; loader_addr/data valid in that same cycle.
//  - loader_en = (state != IDLE).
//  - loader_reset = (state != IDLE); its fall coincides with load_done.
//  Boundary conditions
//  - Address wrap: a write at 16'hFFFF is performed, then further writes are suppressed and load_err is set (no wrap to 0).
//  - ioctl_wr while ioctl_wait high is a protocol error: byte dropped, load_err set.
//  - Run count n=1..255; n=1 is legal (escaped single MARKER).
//  - Download rise while in HOLD: restart at LIT; hold counter cleared.
//  - reset mid-operation: immediate return to IDLE.
//    - loader_reset drops.
//    - No load_done pulse.
// STRUCTURE
//  - Shared package ace_pkg: state enum, MARKER, BASE_ADDR defaults.
//  - Single module; optional sub-module ace_rle_expander (MARK/VAL/run counter) owning ioctl_wait.
// TESTING
//  1. Raw index 0, bytes 11 22 33 -> writes 11@2000, 22@2001, 33@2002; each loader_wr 1 cycle after ioctl_wr.
//  2. Index 1, bytes ED 04 AA 55 -> AA@2000..2003 on 4 consecutive cycles; 55@2004; ioctl_wait high exactly 4 cycles.
//  3. Index 1, ED 01 ED then ED 00 then 77 -> single ED@2000; 77 not written; no error.
//  4. Download ends -> loader_reset high for HOLD_CYCLES; load_done pulses the cycle it falls.
//  5. Downloads cross FFFF -> last write at FFFF; load_err=1; no write to 0000.
//  6. reset asserted during a 200-byte run -> all outputs 0 next cycle; new download restarts at 2000 with load_err clear.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared definitions for the Jupiter Ace snapshot loader: FSM state encoding
// and default values for the loader parameters.
package ace_pkg;

  // LIT: raw/literal bytes, MARK: waiting for run count, VAL: waiting for run
  // value, RUN: expanding a run (host throttled), END: end-of-data seen,
  // HOLD: machine kept in reset after the download has finished.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LIT  = 3'd1,
    ST_MARK = 3'd2,
    ST_VAL  = 3'd3,
    ST_RUN  = 3'd4,
    ST_END  = 3'd5,
    ST_HOLD = 3'd6
  } state_e;

  localparam logic [15:0] BASE_ADDR_DEF   = 16'h2000;
  localparam logic [7:0]  MARKER_DEF      = 8'hED;
  localparam logic [7:0]  SNAP_INDEX_DEF  = 8'h01;
  localparam int          HOLD_CYCLES_DEF = 64;

endpackage

// File: rtl/ace_snapshot_loader.sv
// Sequences an ioctl download into Jupiter Ace memory. Snapshot files are
// run-length expanded (MARKER, count, value; count 0 terminates the data),
// any other file index is copied byte for byte from BASE_ADDR upwards.
//
// Handshake: the host may present a byte (ioctl_wr pulse with ioctl_dout)
// in any cycle where ioctl_wait is low; ioctl_wait is high exactly while a
// run is being written, and a strobe during that window is dropped and
// flagged in load_err. Every memory write is a one-cycle loader_wr pulse with
// loader_addr/loader_data valid in the same cycle.
module ace_snapshot_loader
  import ace_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter logic [7:0]  MARKER      = MARKER_DEF,
  parameter logic [7:0]  SNAP_INDEX  = SNAP_INDEX_DEF,
  parameter int          HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        loader_en,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_wr,
  output logic        loader_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;     // next destination address
  logic        full_q, full_d;     // 16'hFFFF already written
  logic        rle_q, rle_d;       // current download is a snapshot
  logic        err_q, err_d;
  logic        dl_q;               // previous ioctl_download for rise detect
  logic        wr_q, wr_d;
  logic [15:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;       // run writes still to issue
  logic [7:0]  val_q, val_d;       // run value
  logic [15:0] hold_q, hold_d;
  logic        done_q, done_d;

  logic        dl_rise;
  logic        start_req;
  logic        hold_req;
  logic        wr_req;
  logic [7:0]  wr_byte;

  assign dl_rise = ioctl_download & ~dl_q;

  // State and datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      full_q  <= 1'b0;
      rle_q   <= 1'b0;
      err_q   <= 1'b0;
      dl_q    <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= 16'h0000;
      wdata_q <= 8'h00;
      cnt_q   <= 8'h00;
      val_q   <= 8'h00;
      hold_q  <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      rle_q   <= rle_d;
      err_q   <= err_d;
      dl_q    <= ioctl_download;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: byte decoding, run expansion, hold timing and the
  // shared memory-write path.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    full_d    = full_q;
    rle_d     = rle_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    start_req = 1'b0;
    hold_req  = 1'b0;
    wr_req    = 1'b0;
    wr_byte   = ioctl_dout;

    case (state_q)
      ST_IDLE: begin
        if (dl_rise) start_req = 1'b1;
      end
      ST_LIT: begin
        // A byte arriving together with the download fall is still taken;
        // the fall is seen again next cycle because it is level-checked.
        if (ioctl_wr) begin
          if (rle_q && ioctl_dout == MARKER) state_d = ST_MARK;
          else                               wr_req  = 1'b1;
        end else if (!ioctl_download) begin
          hold_req = 1'b1;
        end
      end
      ST_MARK: begin
        if (ioctl_wr) begin
          if (ioctl_dout == 8'h00) begin
            state_d = ST_END;
          end else begin
            cnt_d   = ioctl_dout;
            state_d = ST_VAL;
          end
        end else if (!ioctl_download) begin
          hold_req = 1'b1;
          err_d    = 1'b1;
        end
      end
      ST_VAL: begin
        // First run write is issued straight from the value byte.
        if (ioctl_wr) begin
          val_d   = ioctl_dout;
          cnt_d   = cnt_q - 8'd1;
          wr_req  = 1'b1;
          state_d = ST_RUN;
        end else if (!ioctl_download) begin
          hold_req = 1'b1;
          err_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (ioctl_wr) err_d = 1'b1;
        if (cnt_q != 8'd0) begin
          wr_req  = 1'b1;
          wr_byte = val_q;
          cnt_d   = cnt_q - 8'd1;
        end else if (ioctl_download) begin
          state_d = ST_LIT;
        end else begin
          hold_req = 1'b1;
        end
      end
      ST_END: begin
        if (!ioctl_download) hold_req = 1'b1;
      end
      ST_HOLD: begin
        if (dl_rise) begin
          start_req = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_req) begin
      state_d = ST_LIT;
      rle_d   = (ioctl_index == SNAP_INDEX);
      addr_d  = BASE_ADDR;
      full_d  = 1'b0;
      err_d   = 1'b0;
      hold_d  = 16'h0000;
    end

    if (hold_req) begin
      state_d = ST_HOLD;
      hold_d  = 16'h0000;
    end

    // Writes stop after 16'hFFFF instead of wrapping into ROM space.
    if (wr_req) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        wr_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = wr_byte;
        if (addr_q == 16'hFFFF) full_d = 1'b1;
        else                    addr_d = addr_q + 16'd1;
      end
    end
  end

  assign ioctl_wait   = (state_q == ST_RUN);
  assign loader_en    = (state_q != ST_IDLE);
  assign loader_reset = (state_q != ST_IDLE);
  assign loader_addr  = waddr_q;
  assign loader_data  = wdata_q;
  assign loader_wr    = wr_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Bench for ace_snapshot_loader: table of downloads, hand-written timing
// sequences, randomized downloads and an address-exhaustion run, all checked
// against a byte-stream reference model and a write scoreboard.
module tb_ace_snapshot_loader;

  localparam int HOLD = 64;
  localparam int NTBL = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        loader_en;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic        loader_wr;
  logic        loader_reset;
  logic        load_done;
  logic        load_err;

  ace_snapshot_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .loader_en      (loader_en),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .loader_wr      (loader_wr),
    .loader_reset   (loader_reset),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  idx;
    int          len;
    logic [63:0] b;     // bytes, first byte in the top 8 bits
    int          nwr;
    logic        err;
  } vec_t;

  vec_t        tbl [NTBL];
  int          total = 0;
  int          bad = 0;
  int          wr_count = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  stream[$];
  logic [15:0] last_addr = 16'h0000;
  bit          mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk_sys) begin : mon
    logic [23:0] e;
    if (loader_wr === 1'b1) begin
      wr_count++;
      last_addr = loader_addr;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL write_unexpected: got %0h@%0h expected no write", loader_data, loader_addr);
        end else begin
          e = exp_q.pop_front();
          check("write", {loader_addr, loader_data}, e);
        end
      end
    end
  end

  // reference model
  task automatic push_exp(inout int a, input logic [7:0] v, inout logic err);
    if (a > 32'hFFFF) err = 1'b1;
    else exp_q.push_back({a[15:0], v});
    a++;
  endtask

  task automatic model(input logic [7:0] idx, output logic err);
    int a;
    int i;
    int n;
    logic rle;
    a = 32'h2000;
    i = 0;
    err = 1'b0;
    rle = (idx == 8'h01);
    while (i < stream.size()) begin
      if (rle && stream[i] == 8'hED) begin
        if (i + 1 >= stream.size()) begin err = 1'b1; break; end
        n = int'(stream[i+1]);
        if (n == 0) break;
        if (i + 2 >= stream.size()) begin err = 1'b1; break; end
        for (int k = 0; k < n; k++) push_exp(a, stream[i+2], err);
        i += 3;
      end else begin
        push_exp(a, stream[i], err);
        i++;
      end
    end
  endtask

  // driver tasks (called at posedge + 1)
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (ioctl_wait === 1'b1 && t < 2000) begin
      @(posedge clk_sys); #1;
      t++;
    end
    if (ioctl_wait !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL wait_timeout: ioctl_wait=%b after %0d cycles expected 0", ioctl_wait, t);
    end
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic send_all(input int gap);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i]);
      repeat ($urandom_range(0, gap)) begin @(posedge clk_sys); #1; end
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    wr_count = 0;
    @(posedge clk_sys); #1;
    check("en_reset_on_start", {30'd0, loader_en, loader_reset}, 32'd3);
  endtask

  task automatic end_dl();
    int n = 0;
    int t = 0;
    while (ioctl_wait === 1'b1 && t < 1000) begin
      @(posedge clk_sys); #1;
      t++;
    end
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    while (loader_reset === 1'b1 && n < HOLD + 20) begin
      n++;
      @(posedge clk_sys); #1;
    end
    check("hold_len", n, HOLD);
    check("done_at_reset_fall", {31'd0, load_done}, 32'd1);
    @(posedge clk_sys); #1;
    check("done_one_cycle", {31'd0, load_done}, 32'd0);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic run_stream(input logic [7:0] idx, input int gap, output logic em);
    model(idx, em);
    start_dl(idx);
    send_all(gap);
    end_dl();
  endtask

  // watchdog
  initial begin
    #3000000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation still running at time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic em;
    int wcnt;
    int w;

    tbl[0] = '{8'h00, 3, 64'h1122330000000000, 3, 1'b0};
    tbl[1] = '{8'h01, 4, 64'hED04AA5500000000, 5, 1'b0};
    tbl[2] = '{8'h01, 6, 64'hED01EDED00770000, 1, 1'b0};
    tbl[3] = '{8'h00, 4, 64'hED00ED0500000000, 4, 1'b0};
    tbl[4] = '{8'h01, 1, 64'hED00000000000000, 0, 1'b1};
    tbl[5] = '{8'h01, 2, 64'hED03000000000000, 0, 1'b1};
    tbl[6] = '{8'h02, 2, 64'hED02000000000000, 2, 1'b0};
    tbl[7] = '{8'h01, 3, 64'h12ED000000000000, 1, 1'b0};

    // reset
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_dout = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs", {2'd0, ioctl_wait, loader_en, loader_addr, loader_data,
                            loader_wr, loader_reset, load_done, load_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk_sys); #1;
    check("idle_outputs", {2'd0, ioctl_wait, loader_en, loader_addr, loader_data,
                           loader_wr, loader_reset, load_done, load_err}, 32'd0);

    // table-driven downloads
    for (int v = 0; v < NTBL; v++) begin
      stream.delete();
      for (int i = 0; i < tbl[v].len; i++) stream.push_back(tbl[v].b[63-8*i -: 8]);
      run_stream(tbl[v].idx, 1, em);
      check("tbl_nwr", wr_count, tbl[v].nwr);
      check("tbl_err", {31'd0, load_err}, {31'd0, tbl[v].err});
    end

    // literal latency: write visible one cycle after the strobe
    exp_q.push_back({16'h2000, 8'h11});
    start_dl(8'h00);
    send_byte(8'h11);
    check("lit_latency", {7'd0, loader_wr, loader_addr, loader_data}, {7'd1, 16'h2000, 8'h11});
    @(posedge clk_sys); #1;
    check("lit_one_cycle", {31'd0, loader_wr}, 32'd0);
    end_dl();

    // run of 4: wait high exactly 4 cycles, 4 back-to-back writes
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h2000 + 16'(i), 8'hAA});
    exp_q.push_back({16'h2004, 8'h55});
    start_dl(8'h01);
    send_byte(8'hED);
    send_byte(8'h04);
    send_byte(8'hAA);
    w = 0;
    wcnt = 0;
    while (ioctl_wait === 1'b1 && w < 300) begin
      if (loader_wr === 1'b1) wcnt++;
      w++;
      @(posedge clk_sys); #1;
    end
    check("wait_len", w, 4);
    check("run_writes", wcnt, 4);
    send_byte(8'h55);
    end_dl();
    check("run_no_err", {31'd0, load_err}, 32'd0);

    // strobe during ioctl_wait is dropped and flagged
    stream.delete();
    stream.push_back(8'hED);
    stream.push_back(8'h03);
    stream.push_back(8'h66);
    model(8'h01, em);
    start_dl(8'h01);
    send_all(0);
    ioctl_dout = 8'h99;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    end_dl();
    check("wait_violation_err", {31'd0, load_err}, 32'd1);
    check("wait_violation_nwr", wr_count, 3);

    // randomized downloads
    for (int r = 0; r < 24; r++) begin
      logic [7:0] idx;
      int len;
      case ($urandom_range(0, 3))
        0:       idx = 8'h00;
        3:       idx = 8'h5A;
        default: idx = 8'h01;
      endcase
      stream.delete();
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        if (idx == 8'h01 && $urandom_range(0, 4) == 0) begin
          stream.push_back(8'hED);
          stream.push_back(8'($urandom_range(0, 9)));
        end else begin
          stream.push_back(8'($urandom_range(0, 255)));
        end
      end
      run_stream(idx, 2, em);
      check("rand_err", {31'd0, load_err}, {31'd0, em});
    end

    // download running past 16'hFFFF
    stream.delete();
    for (int j = 0; j < 225; j++) begin
      stream.push_back(8'hED);
      stream.push_back(8'hFF);
      stream.push_back(8'(j));
    end
    run_stream(8'h01, 0, em);
    check("cross_err", {31'd0, load_err}, 32'd1);
    check("cross_last_addr", {16'd0, last_addr}, 32'h0000FFFF);
    check("cross_nwr", wr_count, 32'hE000);

    // reset in the middle of a 200-byte run
    mon_en = 1'b0;
    start_dl(8'h01);
    send_byte(8'hED);
    send_byte(8'hC8);
    send_byte(8'h5A);
    repeat (10) begin @(posedge clk_sys); #1; end
    check("run_active", {31'd0, ioctl_wait}, 32'd1);
    ioctl_dout = 8'h01;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    check("err_before_reset", {31'd0, load_err}, 32'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    check("reset_mid_run", {2'd0, ioctl_wait, loader_en, loader_addr, loader_data,
                            loader_wr, loader_reset, load_done, load_err}, 32'd0);
    reset = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (load_done === 1'b1 || loader_wr === 1'b1) wcnt++;
      @(posedge clk_sys); #1;
    end
    check("no_done_after_reset", wcnt, 0);
    exp_q.delete();
    mon_en = 1'b1;
    exp_q.push_back({16'h2000, 8'hC3});
    start_dl(8'h00);
    check("restart_err_clear", {31'd0, load_err}, 32'd0);
    send_byte(8'hC3);
    check("restart_addr", {8'd0, loader_addr, loader_data}, {8'd0, 16'h2000, 8'hC3});
    end_dl();
    check("restart_err_end", {31'd0, load_err}, 32'd0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
